// File: rtl/systolic1x4_feeder_if.sv
// Feeder bus: buffer write port and run control from the host side,
// skewed operand stream and run status toward the PE row.
interface systolic1x4_feeder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_b;
    logic [4*DATA_W-1:0]   wr_a;
    logic [ADDR_W:0]       len;
    logic                  start;
    logic                  arr_rst;
    logic [DATA_W-1:0]     b0;
    logic [DATA_W-1:0]     a0;
    logic [DATA_W-1:0]     a1;
    logic [DATA_W-1:0]     a2;
    logic [DATA_W-1:0]     a3;
    logic                  busy;
    logic                  done;

    modport master (
        output wr_en, wr_addr, wr_b, wr_a, len, start,
        input  arr_rst, b0, a0, a1, a2, a3, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_b, wr_a, len, start,
        output arr_rst, b0, a0, a1, a2, a3, busy, done
    );
endinterface

// File: rtl/systolic1x4_feeder.sv
// Operand feeder and skew stage for a 1x4 systolic PE row.
// Buffers up to DEPTH operand vectors, clears the array, streams B into b0
// and delays lane i of A by i cycles so it meets its B at PE i.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; buffer writes accepted
// CLEAR  | arr_rst high for one cycle, data outputs zero
// STREAM | t < len_q: buffer entries read and pushed into the lanes
// DRAIN  | three cycles of zeros fed while the skew chains empty
// DONE   | done pulse, array results final
module systolic1x4_feeder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic clk,
    input  logic rst,
    systolic1x4_feeder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              state_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W+1:0]   t_q;
    logic                arr_rst_q;
    logic                busy_q;
    logic                done_q;

    logic [DATA_W-1:0]   mem_b [DEPTH];
    logic [4*DATA_W-1:0] mem_a [DEPTH];

    logic [DATA_W-1:0]   b0_q, a0_q, a1_q, a2_q, a3_q;
    logic [DATA_W-1:0]   d1_q, d2a_q, d2b_q, d3a_q, d3b_q, d3c_q;

    logic [ADDR_W:0]     len_clamp;
    logic [ADDR_W+1:0]   t_last;
    logic                fetch_ok;
    logic                advance;
    logic [ADDR_W-1:0]   rd_idx;
    logic [DATA_W-1:0]   f_b;
    logic [4*DATA_W-1:0] f_a;

    // Length clamp, end-of-run compare and the buffer read feeding the lanes.
    // t_q is the stream cycle being produced at the next edge.
    always_comb begin
        len_clamp = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
        t_last    = {1'b0, len_q} + (ADDR_W+2)'(3);
        fetch_ok  = t_q < {1'b0, len_q};
        rd_idx    = t_q[ADDR_W-1:0];
        advance   = ((state_q == S_CLEAR) && (len_q != '0)) ||
                    (((state_q == S_STREAM) || (state_q == S_DRAIN)) && (t_q != t_last));
        f_b = '0;
        f_a = '0;
        if (fetch_ok) begin
            f_b = mem_b[rd_idx];
            f_a = mem_a[rd_idx];
        end
    end

    // Operand buffer; writes only in IDLE so a run sees stable data.
    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en && (state_q == S_IDLE)) begin
            mem_b[bus.wr_addr] <= bus.wr_b;
            mem_a[bus.wr_addr] <= bus.wr_a;
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            t_q       <= '0;
            arr_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q   <= S_CLEAR;
                        len_q     <= len_clamp;
                        t_q       <= '0;
                        arr_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    arr_rst_q <= 1'b0;
                    if (len_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_STREAM;
                        t_q     <= t_q + (ADDR_W+2)'(1);
                    end
                end
                S_STREAM, S_DRAIN: begin
                    if (t_q == t_last) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= fetch_ok ? S_STREAM : S_DRAIN;
                        t_q     <= t_q + (ADDR_W+2)'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Data path: lane i passes through i extra registers before its output.
    // Outside streaming everything, including the skew chains, is held at zero.
    always_ff @(posedge clk) begin
        if (rst || !advance) begin
            b0_q  <= '0;
            a0_q  <= '0;
            a1_q  <= '0;
            a2_q  <= '0;
            a3_q  <= '0;
            d1_q  <= '0;
            d2a_q <= '0;
            d2b_q <= '0;
            d3a_q <= '0;
            d3b_q <= '0;
            d3c_q <= '0;
        end else begin
            b0_q  <= f_b;
            a0_q  <= f_a[DATA_W-1:0];
            d1_q  <= f_a[2*DATA_W-1:DATA_W];
            a1_q  <= d1_q;
            d2a_q <= f_a[3*DATA_W-1:2*DATA_W];
            d2b_q <= d2a_q;
            a2_q  <= d2b_q;
            d3a_q <= f_a[4*DATA_W-1:3*DATA_W];
            d3b_q <= d3a_q;
            d3c_q <= d3b_q;
            a3_q  <= d3c_q;
        end
    end

    assign bus.arr_rst = arr_rst_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.b0      = b0_q;
    assign bus.a0      = a0_q;
    assign bus.a1      = a1_q;
    assign bus.a2      = a2_q;
    assign bus.a3      = a3_q;
endmodule

// File: tb/tb_systolic1x4_feeder.sv
// Scoreboard bench for systolic1x4_feeder with a behavioural 1x4 PE row.
module tb_systolic1x4_feeder;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic1x4_feeder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    systolic1x4_feeder #(.DATA_W(DW), .DEPTH(16), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic          arr_rst;
        logic [DW-1:0] b0;
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        logic [DW-1:0] a2;
        logic [DW-1:0] a3;
        logic          done;
    } rec_t;

    typedef struct packed {
        logic [39:0] c0;
        logic [39:0] c1;
        logic [39:0] c2;
        logic [39:0] c3;
    } cexp_t;

    rec_t  exp_q[$];
    cexp_t exp_c[$];
    rec_t  mon_e;
    cexp_t mon_c;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    logic [DW-1:0] m_b [16];
    logic [DW-1:0] m_a [16][4];

    // Behavioural PE row: b ripples one PE per cycle, each PE accumulates a_i*b.
    logic [39:0]   acc0, acc1, acc2, acc3;
    logic [DW-1:0] bq1, bq2, bq3;
    always @(posedge clk) begin
        if (bus.arr_rst) begin
            acc0 <= '0; acc1 <= '0; acc2 <= '0; acc3 <= '0;
            bq1 <= '0; bq2 <= '0; bq3 <= '0;
        end else begin
            acc0 <= acc0 + 40'(bus.a0) * 40'(bus.b0);
            acc1 <= acc1 + 40'(bus.a1) * 40'(bq1);
            acc2 <= acc2 + 40'(bus.a2) * 40'(bq2);
            acc3 <= acc3 + 40'(bus.a3) * 40'(bq3);
            bq1 <= bus.b0;
            bq2 <= bq1;
            bq3 <= bq2;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every busy cycle consumes one expected record; idle cycles must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_unexpected actual=busy expected=idle at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("arr_rst", 64'(bus.arr_rst), 64'(mon_e.arr_rst));
                    chk("b0", 64'(bus.b0), 64'(mon_e.b0));
                    chk("a0", 64'(bus.a0), 64'(mon_e.a0));
                    chk("a1", 64'(bus.a1), 64'(mon_e.a1));
                    chk("a2", 64'(bus.a2), 64'(mon_e.a2));
                    chk("a3", 64'(bus.a3), 64'(mon_e.a3));
                    chk("done", 64'(bus.done), 64'(mon_e.done));
                    if (mon_e.done) begin
                        if (exp_c.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL c_expect_missing at %0t", $time);
                        end else begin
                            mon_c = exp_c.pop_front();
                            chk("c0", 64'(acc0), 64'(mon_c.c0));
                            chk("c1", 64'(acc1), 64'(mon_c.c1));
                            chk("c2", 64'(acc2), 64'(mon_c.c2));
                            chk("c3", 64'(acc3), 64'(mon_c.c3));
                        end
                    end
                end
            end else begin
                chk("idle_busy", 64'(bus.busy), 64'd0);
                chk("idle_ctrl", {62'd0, bus.arr_rst, bus.done}, 64'd0);
                chk("idle_data", {bus.b0, bus.a0, bus.a1, bus.a2} | 64'(bus.a3), 64'd0);
            end
        end
    end

    // Expected per-cycle outputs of one run, from the bench's copy of the buffer.
    task automatic push_run(input int len, input int c0, input int c1, input int c2, input int c3);
        int   lq;
        rec_t r;
        cexp_t c;
        lq = (len > 16) ? 16 : len;
        r = '0;
        r.arr_rst = 1'b1;
        exp_q.push_back(r);
        if (lq > 0) begin
            for (int t = 0; t <= lq + 2; t++) begin
                r = '0;
                r.b0 = (t < lq) ? m_b[t] : '0;
                r.a0 = (t     < lq)                ? m_a[t][0]   : '0;
                r.a1 = (t - 1 >= 0 && t - 1 < lq)  ? m_a[t-1][1] : '0;
                r.a2 = (t - 2 >= 0 && t - 2 < lq)  ? m_a[t-2][2] : '0;
                r.a3 = (t - 3 >= 0 && t - 3 < lq)  ? m_a[t-3][3] : '0;
                exp_q.push_back(r);
            end
        end
        r = '0;
        r.done = 1'b1;
        exp_q.push_back(r);
        c.c0 = 40'(c0); c.c1 = 40'(c1); c.c2 = 40'(c2); c.c3 = 40'(c3);
        exp_c.push_back(c);
    endtask

    task automatic set_wr(input int addr, input int b, input int x0, input int x1, input int x2, input int x3);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_b    = DW'(b);
        bus.wr_a    = {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
    endtask

    task automatic model_wr(input int addr, input int b, input int x0, input int x1, input int x2, input int x3);
        m_b[addr] = DW'(b);
        m_a[addr][0] = DW'(x0);
        m_a[addr][1] = DW'(x1);
        m_a[addr][2] = DW'(x2);
        m_a[addr][3] = DW'(x3);
    endtask

    task automatic write(input int addr, input int b, input int x0, input int x1, input int x2, input int x3);
        model_wr(addr, b, x0, x1, x2, x3);
        @(posedge clk); #1;
        set_wr(addr, b, x0, x1, x2, x3);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic do_start(input int len);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = (AW+1)'(len);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (bus.busy !== 1'b0 && n < bound) begin
            @(posedge clk); #2;
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL run_timeout actual=busy expected=idle within %0d cycles", bound);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_b = '0; bus.wr_a = '0;
        bus.len = '0; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_arr_rst", 64'(bus.arr_rst), 64'd0);
        chk("rst_b0", 64'(bus.b0), 64'd0);
        chk("rst_a", {bus.a0, bus.a1, bus.a2, bus.a3}, 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic run; entry 2 written in the same cycle as start.
        write(0, 5, 5, 5, 5, 5);
        write(1, 10, 10, 5, 5, 5);
        model_wr(2, 20, 20, 5, 5, 5);
        push_run(3, 525, 175, 175, 175);
        @(posedge clk); #1;
        set_wr(2, 20, 20, 5, 5, 5);
        bus.start = 1'b1;
        bus.len   = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        wait_idle(40);

        // Skew pattern A_i[k]=16i+k, B=1.
        for (int k = 0; k < 4; k++) write(k, 1, k, 16 + k, 32 + k, 48 + k);
        push_run(4, 6, 70, 134, 198);
        do_start(4);
        wait_idle(40);

        // Write and start while busy are both dropped.
        push_run(4, 6, 70, 134, 198);
        do_start(4);
        @(posedge clk); @(posedge clk); #1;
        set_wr(0, 999, 999, 999, 999, 999);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        wait_idle(40);
        push_run(4, 6, 70, 134, 198);
        do_start(4);
        wait_idle(40);

        // Reset during STREAM at t=1, then a normal run on the kept buffer.
        push_run(4, 0, 0, 0, 0);
        do_start(4);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_c.delete();
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_data", {bus.b0, bus.a0, bus.a1, bus.a2} | 64'(bus.a3), 64'd0);
        repeat (4) @(posedge clk);
        push_run(4, 6, 70, 134, 198);
        do_start(4);
        wait_idle(40);

        // Zero length: CLEAR then DONE, accumulators cleared.
        push_run(0, 0, 0, 0, 0);
        do_start(0);
        wait_idle(10);

        // Length 20 clamps to 16, followed back-to-back by a length-3 run.
        for (int k = 0; k < 16; k++) write(k, 1, 1, 2, 3, 4);
        push_run(20, 16, 32, 48, 64);
        push_run(3, 3, 6, 9, 12);
        do_start(20);
        repeat (16 + 4) @(posedge clk);
        #1;
        chk("b2b_in_done", 64'(bus.done), 64'd1);
        bus.start = 1'b1;
        bus.len   = 5'd3;
        @(posedge clk); #1;
        chk("b2b_idle_gap", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_arr_rst", 64'(bus.arr_rst), 64'd1);
        wait_idle(40);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic1x4_feeder.md
Name: systolic1x4_feeder

Overview:
Operand feeder and skew stage directly upstream of the 1x4 systolic PE row (ports a0..a3, b0, c0..c3).
- Holds up to DEPTH operand vectors in a local buffer.
- On start, clears the array accumulators, streams B into b0 and skews A so that a_i reaches PE i in the same cycle as the matching b.
- Drives zeros during drain, then pulses done when c0..c3 hold final dot products.

Parameters:
DATA_W, 16, operand width (matches array a*/b0 inputs)
DEPTH, 16, operand buffer entries (max stream length)
ADDR_W, 4, buffer address width, log2(DEPTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  buffer write strobe, ignored while busy=1
wr_addr  input  ADDR_W  buffer write index
wr_b  input  DATA_W  B operand for entry wr_addr
wr_a  input  4*DATA_W  packed {A3,A2,A1,A0} for entry wr_addr
len  input  ADDR_W+1  stream length, sampled on accepted start
start  input  1  single-cycle request, accepted only in IDLE
arr_rst  output  1  accumulator clear to array, high exactly one cycle per run
b0  output  DATA_W  to array b0
a0,a1,a2,a3  output  DATA_W each  to array a0..a3
busy  output  1  high from CLEAR through DONE inclusive
done  output  1  one-cycle pulse, array results final

Behaviour:
- Reset: state IDLE; arr_rst, b0, a0..a3, busy, done all 0. Buffer contents not reset. rst mid-run aborts immediately, with no done and no arr_rst.
- FSM: IDLE -> CLEAR on start. CLEAR -> STREAM if len_q>0, else -> DONE. STREAM (len_q cycles) -> DRAIN (3 cycles) -> DONE (1 cycle) -> IDLE.
- len_q = min(len, DEPTH), latched when start is accepted. start in any non-IDLE state is ignored.
- CLEAR: arr_rst=1, all data outputs 0.
- All outputs are registered and change only on clk edges.
- Let t=0 be the first STREAM cycle; t runs 0..len_q+2 across STREAM and DRAIN. In cycle t:
  - b0 = B[t] if t<len_q, else 0.
  - a_i = A_i[t-i] if 0 <= t-i < len_q, else 0, for i=0..3.
  - The per-lane skew is implemented as shift registers fed from the buffer read.
- DONE is cycle t=len_q+3: done=1, all data outputs 0, busy=1. Next cycle busy=0.
- Array contract: after the done cycle's edge, c_i = sum over k of A_i[k]*B[k]. The feeder does not observe c.
- Writes are accepted only in IDLE. wr_en in any other state is dropped, so buffer data is stable for the whole run.
- wr_en and start in the same IDLE cycle: the write takes effect first and is visible to the run.
- len=0: CLEAR then DONE (done 2 cycles after start). The array is cleared, so c=0.
- Back-to-back: start asserted in the DONE cycle is ignored. It is accepted the cycle after, in IDLE.

Test Plan:
- Basic run: write entries 0..2 with B={5,10,20}, A0={5,10,20}, A1=A2=A3=5; len=3; start.
  -> arr_rst pulses 1 cycle after start; b0 sequence 5,10,20,0,0,0; a1 sequence 0,5,5,5,0,0.
  -> done at t=6; array gives c0=525, c1=c2=c3=175.
- Skew check: A_i[k]=16*i+k, B all 1, len=4, start.
  -> a3 = 0,0,0,48,49,50,51 over t=0..6; a0 = 0..3 then 0.
  -> c0=6, c1=70, c2=134, c3=198.
- Protection: wr_en to entry 0 while busy, and start at t=1.
  -> buffer unchanged, no second run, exactly one done pulse.
- len=0 and len=20 with DEPTH=16.
  -> len=0: done 2 cycles after start, no nonzero data.
  -> len=20: clamped, 16 STREAM cycles, done at t=19.
- Reset mid-STREAM at t=1.
  -> next cycle all outputs 0, busy=0, no done.
  -> a following start runs normally with the preserved buffer.
- Back-to-back: start in the DONE cycle is ignored; start one cycle later is accepted.
  -> arr_rst pulses again, and the second run's results are independent of the first.
